// File: rtl/fifo_tx_drain.sv
// Burst read sequencer: pops bytes from the receive FIFO and feeds them to the UART
// transmitter one at a time, stopping on count, FIFO empty, abort or transmit timeout.
module fifo_tx_drain #(
  parameter int unsigned GAP_CYCLES = 0,
  parameter int unsigned TX_TIMEOUT = 200000,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  input  logic             abort,
  input  logic             fifo_empty,
  input  logic [7:0]       fifo_dout,
  output logic             fifo_ren,
  output logic             tx_dv,
  output logic [7:0]       tx_byte,
  input  logic             tx_done,
  output logic             busy,
  output logic             done,
  output logic             timeout_err,
  output logic [CNT_W-1:0] sent_count
);

  localparam int unsigned TmoW = $clog2(TX_TIMEOUT + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TX_TIMEOUT - 1);
  // Only compared while in StGap, which is unreachable when GAP_CYCLES is 0.
  localparam logic [7:0] GapLast = 8'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle, StCheck, StFetch, StLoad, StWaitTx, StGap, StFinish
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] target_q, target_d;
  logic [CNT_W-1:0] sent_q, sent_d;
  logic [TmoW-1:0]  tmo_q, tmo_d;
  logic [7:0]       gap_q, gap_d;
  logic [7:0]       byte_q, byte_d;
  logic             terr_q, terr_d;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      target_q <= '0;
      sent_q   <= '0;
      tmo_q    <= '0;
      gap_q    <= '0;
      byte_q   <= 8'h00;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      sent_q   <= sent_d;
      tmo_q    <= tmo_d;
      gap_q    <= gap_d;
      byte_q   <= byte_d;
      terr_q   <= terr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    sent_d   = sent_q;
    tmo_d    = tmo_q;
    gap_d    = gap_q;
    byte_d   = byte_q;
    terr_d   = terr_q;
    fifo_ren = 1'b0;
    tx_dv    = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          target_d = count;
          sent_d   = '0;
          terr_d   = 1'b0;
          state_d  = StCheck;
        end
      end
      StCheck: begin
        if (abort || fifo_empty || ((target_q != '0) && (sent_q == target_q))) begin
          state_d = StFinish;
        end else begin
          fifo_ren = 1'b1;
          state_d  = StFetch;
        end
      end
      StFetch: begin
        byte_d  = fifo_dout;
        state_d = StLoad;
      end
      StLoad: begin
        tx_dv   = 1'b1;
        tmo_d   = '0;
        state_d = StWaitTx;
      end
      StWaitTx: begin
        // abort is deliberately not looked at: a loaded byte always finishes.
        if (tx_done) begin
          sent_d  = sent_q + CNT_W'(1);
          gap_d   = 8'h00;
          state_d = (GAP_CYCLES > 0) ? StGap : StCheck;
        end else if (tmo_q == TmoLast) begin
          terr_d  = 1'b1;
          state_d = StFinish;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      StGap: begin
        if (abort) begin
          state_d = StFinish;
        end else if (gap_q == GapLast) begin
          state_d = StCheck;
        end else begin
          gap_d = gap_q + 8'h01;
        end
      end
      StFinish: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy        = (state_q != StIdle);
  assign tx_byte     = byte_q;
  assign timeout_err = terr_q;
  assign sent_count  = sent_q;

endmodule

// File: tb/tb_fifo_tx_drain.sv
// Bench for fifo_tx_drain: FIFO and transmitter models plus a queue-based reference of
// which bytes each drain should send, with timing checks on the key latencies.
module tb_fifo_tx_drain;

  localparam int Gap = 3;
  localparam int Tmo = 50;

  logic       clk_in = 1'b0;
  logic       reset, start, abort, fifo_empty, tx_done;
  logic       fifo_ren, tx_dv, busy, done, timeout_err;
  logic [7:0] count, fifo_dout, tx_byte, sent_count;

  logic [7:0] mem [0:2047];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int ren_viol = 0;
  int tx_cnt = 0;
  int tx_delay = 5;
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  int dv_bytes[$];
  int dv_cyc[$];
  int ren_cyc[$];
  int txd_cyc[$];
  int done_cyc[$];
  int ref_q[$];

  fifo_tx_drain #(.GAP_CYCLES(Gap), .TX_TIMEOUT(Tmo), .CNT_W(8)) dut (
    .clk_in(clk_in), .reset(reset), .start(start), .count(count), .abort(abort),
    .fifo_empty(fifo_empty), .fifo_dout(fifo_dout), .fifo_ren(fifo_ren), .tx_dv(tx_dv),
    .tx_byte(tx_byte), .tx_done(tx_done), .busy(busy), .done(done),
    .timeout_err(timeout_err), .sent_count(sent_count)
  );

  always #5 clk_in = ~clk_in;

  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk_in) cyc <= cyc + 1;

  // FIFO model: data appears the cycle after the pop.
  always @(posedge clk_in) begin
    if (fifo_ren) begin
      if (rd_ptr == wr_ptr) ren_viol <= ren_viol + 1;
      else begin
        fifo_dout <= mem[rd_ptr];
        rd_ptr    <= rd_ptr + 1;
      end
    end
  end

  // Transmitter model: tx_done tx_delay cycles after load; tx_delay 0 never answers.
  always @(posedge clk_in) begin
    tx_done <= 1'b0;
    if (reset) begin
      tx_cnt <= 0;
    end else if (tx_dv) begin
      tx_cnt <= tx_delay;
    end else if (tx_cnt != 0) begin
      tx_cnt <= tx_cnt - 1;
      if (tx_cnt == 1) tx_done <= 1'b1;
    end
  end

  always @(posedge clk_in) begin
    if (tx_dv) begin
      dv_bytes.push_back(int'(tx_byte));
      dv_cyc.push_back(cyc);
    end
    if (fifo_ren) ren_cyc.push_back(cyc);
    if (tx_done) txd_cyc.push_back(cyc);
    if (done) done_cyc.push_back(cyc);
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic load(input int b);
    mem[wr_ptr] = 8'(b);
    wr_ptr++;
    ref_q.push_back(b & 255);
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk_in);
      if (done) break;
    end
    chk({tag, "_done_seen"}, int'(done), 1);
  endtask

  task automatic wait_dv(input string tag);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk_in);
      if (tx_dv) break;
    end
    chk({tag, "_dv_seen"}, int'(tx_dv), 1);
  endtask

  task automatic pulse_start(input int cnt, output int sc);
    @(negedge clk_in);
    count = 8'(cnt);
    start = 1'b1;
    sc    = cyc;
    @(negedge clk_in);
    start = 1'b0;
  endtask

  // Normal drain: expected bytes are the head of ref_q, limited by cnt (0 = all).
  task automatic drain(input string tag, input int cnt);
    int sc, n, bd, br, bt, bdn, e, a;
    bd  = dv_bytes.size();
    br  = ren_cyc.size();
    bt  = txd_cyc.size();
    bdn = done_cyc.size();
    n   = (cnt == 0 || cnt > ref_q.size()) ? ref_q.size() : cnt;
    pulse_start(cnt, sc);
    chk({tag, "_terr_clr"}, int'(timeout_err), 0);
    wait_done(tag, 6000);
    @(negedge clk_in);
    chk({tag, "_dv_n"}, dv_bytes.size() - bd, n);
    chk({tag, "_ren_n"}, ren_cyc.size() - br, n);
    chk({tag, "_done_n"}, done_cyc.size() - bdn, 1);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_sent"}, int'(sent_count), n % 256);
    for (int i = 0; i < n; i++) begin
      e = ref_q.pop_front();
      a = (bd + i < dv_bytes.size()) ? dv_bytes[bd + i] : -1;
      chk({tag, "_byte"}, a, e);
    end
    chk({tag, "_left"}, wr_ptr - rd_ptr, ref_q.size());
    if (n >= 1 && ren_cyc.size() > br && dv_cyc.size() > bd) begin
      chk({tag, "_ren_lat"}, ren_cyc[br] - sc, 1);
      chk({tag, "_dv_lat"}, dv_cyc[bd] - sc, 3);
    end
    if (n >= 2 && ren_cyc.size() > br + 1 && txd_cyc.size() > bt)
      chk({tag, "_gap"}, ren_cyc[br + 1] - txd_cyc[bt], 1 + Gap);
    if (n == 0 && done_cyc.size() > bdn)
      chk({tag, "_done_lat"}, done_cyc[bdn] - sc, 2);
  endtask

  initial begin
    int sc, bd, br, bdn, a, e, nb, cn;
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    count = 8'h00;
    @(negedge clk_in);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ren", int'(fifo_ren), 0);
    chk("rst_dv", int'(tx_dv), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_terr", int'(timeout_err), 0);
    chk("rst_byte", int'(tx_byte), 0);
    chk("rst_sent", int'(sent_count), 0);
    @(negedge clk_in);
    reset = 1'b0;

    // Three bytes, unlimited count.
    tx_delay = int'($urandom_range(3, 15));
    load(8'h41); load(8'h42); load(8'h43);
    drain("t1", 0);

    // Count limits the drain; leftovers stay queued.
    for (int i = 0; i < 5; i++) load(int'($urandom_range(0, 255)));
    drain("t2", 2);
    chk("t2_not_empty", int'(fifo_empty), 0);
    drain("t2_flush", 0);

    // Empty FIFO.
    drain("t3", 4);

    // Abort raised while the first byte is in flight.
    tx_delay = 30;
    for (int i = 0; i < 4; i++) load(int'($urandom_range(0, 255)));
    bd = dv_bytes.size(); br = ren_cyc.size(); bdn = done_cyc.size();
    pulse_start(0, sc);
    wait_dv("t4");
    repeat (10) @(negedge clk_in);
    abort = 1'b1;
    wait_done("t4", 200);
    abort = 1'b0;
    @(negedge clk_in);
    chk("t4_sent", int'(sent_count), 1);
    chk("t4_ren_n", ren_cyc.size() - br, 1);
    chk("t4_dv_n", dv_bytes.size() - bd, 1);
    chk("t4_done_n", done_cyc.size() - bdn, 1);
    e = ref_q.pop_front();
    a = (dv_bytes.size() > bd) ? dv_bytes[bd] : -1;
    chk("t4_byte", a, e);
    chk("t4_left", wr_ptr - rd_ptr, 3);
    drain("t4_flush", 0);

    // Transmitter never answers: timeout, then a new start clears the error.
    tx_delay = 0;
    load(int'($urandom_range(0, 255))); load(int'($urandom_range(0, 255)));
    bd = dv_bytes.size(); br = ren_cyc.size(); bdn = done_cyc.size();
    pulse_start(0, sc);
    wait_done("t5", 200);
    chk("t5_terr_at_done", int'(timeout_err), 1);
    @(negedge clk_in);
    chk("t5_terr_sticky", int'(timeout_err), 1);
    chk("t5_sent", int'(sent_count), 0);
    chk("t5_ren_n", ren_cyc.size() - br, 1);
    chk("t5_dv_n", dv_bytes.size() - bd, 1);
    if (done_cyc.size() > bdn && dv_cyc.size() > bd) begin
      a = done_cyc[bdn] - dv_cyc[bd];
      chk("t5_tmo_window", int'(a >= Tmo && a <= Tmo + 1), 1);
    end
    void'(ref_q.pop_front());
    tx_delay = 5;
    drain("t5_restart", 0);

    // Asynchronous reset while waiting on the transmitter, then a normal drain.
    tx_delay = 40;
    for (int i = 0; i < 3; i++) load(int'($urandom_range(0, 255)));
    pulse_start(0, sc);
    wait_dv("t6");
    repeat (5) @(negedge clk_in);
    #2 reset = 1'b1;
    #1;
    chk("t6_busy", int'(busy), 0);
    chk("t6_ren", int'(fifo_ren), 0);
    chk("t6_dv", int'(tx_dv), 0);
    chk("t6_byte", int'(tx_byte), 0);
    chk("t6_done", int'(done), 0);
    chk("t6_terr", int'(timeout_err), 0);
    chk("t6_sent", int'(sent_count), 0);
    @(posedge clk_in);
    @(negedge clk_in);
    reset = 1'b0;
    void'(ref_q.pop_front());
    tx_delay = int'($urandom_range(1, 8));
    for (int i = 0; i < 2; i++) load(int'($urandom_range(0, 255)));
    drain("t6_after", 0);

    // Randomised drains.
    for (int it = 0; it < 6; it++) begin
      nb = int'($urandom_range(0, 6));
      cn = int'($urandom_range(0, 7));
      tx_delay = int'($urandom_range(1, 12));
      for (int i = 0; i < nb; i++) load(int'($urandom_range(0, 255)));
      drain("rnd", cn);
      drain("rnd_flush", 0);
    end

    // count=0 drain longer than 2^CNT_W: sent_count wraps.
    tx_delay = 1;
    for (int i = 0; i < 260; i++) load(int'($urandom_range(0, 255)));
    drain("wrap", 0);

    chk("no_pop_when_empty", ren_viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
